// File: rtl/instr_fetch_ir.sv
// -----------------------------------------------------------------------------
// instr_fetch_ir
// Fetch stage plus instruction register for the microcoded control unit.
// Keeps the PC and fetches one word per control-store strobe over a req/ack
// handshake. The word is latched into the IR, which is decoded into opcode,
// packed register indices, funct bits and a sign-extended immediate.
// Optional feature macro: FETCH_TIMEOUT_EN (bounded memory wait, sets fetch_err).
// -----------------------------------------------------------------------------
module instr_fetch_ir #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   PC_RESET = '0,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  input  logic            pc_we,
  input  logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     ir,
  output logic [6:0]      opcode,
  output logic [14:0]     r,
  output logic [2:0]      funct3,
  output logic            funct7_b5,
  output logic [XLEN-1:0] imm,
  output logic            ir_valid,
  output logic            fetch_busy,
  output logic            fetch_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [31:0]     IR_NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [31:0]     ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            imem_req_q, imem_req_d;
  logic            redirect_q, redirect_d;
  logic            fetch_err_q, fetch_err_d;
  logic [XLEN-1:0] pc_load_s;
  logic [31:0]     imm32_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Redirect targets are always word aligned.
  assign pc_load_s = pc_next & ALIGN_MASK;

  // State, PC, IR and handshake registers; reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_RESET;
      fetch_addr_q <= PC_RESET;
      ir_q         <= IR_NOP;
      ir_valid_q   <= 1'b0;
      imem_req_q   <= 1'b0;
      redirect_q   <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      imem_req_q   <= imem_req_d;
      redirect_q   <= redirect_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait-cycle counter for the bounded memory wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // Next-state logic: fetch start, completion, redirects and timeout.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    imem_req_d   = imem_req_q;
    redirect_d   = redirect_q;
    fetch_err_d  = fetch_err_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d      = ST_WAIT;
          fetch_addr_d = pc_q;
          imem_req_d   = 1'b1;
          ir_valid_d   = 1'b0;
          fetch_err_d  = 1'b0;
          redirect_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
        if (pc_we) begin
          pc_d = pc_load_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          // Completion wins over a simultaneous timeout.
          state_d    = ST_IDLE;
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          imem_req_d = 1'b0;
          if (pc_we) begin
            pc_d = pc_load_s;
          end else if (redirect_q) begin
            pc_d = pc_q;
          end else begin
            pc_d = fetch_addr_q + PC_STEP;
          end
        end else begin
          // A redirect mid-fetch moves the PC now; imem_addr keeps the old address.
          if (pc_we) begin
            pc_d       = pc_load_s;
            redirect_d = 1'b1;
          end else begin
            pc_d = pc_q;
          end
`ifdef FETCH_TIMEOUT_EN
          if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            state_d     = ST_IDLE;
            imem_req_d  = 1'b0;
            fetch_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
`endif
        end
      end
      default: begin
        state_d    = ST_IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // Immediate decode for the opcode currently held in the IR.
  always_comb begin
    imm32_s = 32'h0000_0000;
    case (ir_q[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        imm32_s = {{20{ir_q[31]}}, ir_q[31:20]};
      OP_STORE:
        imm32_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH:
        imm32_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32_s = {ir_q[31:12], 12'h000};
      OP_JAL:
        imm32_s = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:
        imm32_s = 32'h0000_0000;
    endcase
  end

  assign imm        = XLEN'($signed(imm32_s));
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[6:0];
  assign r          = {ir_q[11:7], ir_q[19:15], ir_q[24:20]};
  assign funct3     = ir_q[14:12];
  assign funct7_b5  = ir_q[30];
  assign ir_valid   = ir_valid_q;
  assign imem_req   = imem_req_q;
  assign imem_addr  = fetch_addr_q;
  assign fetch_busy = (state_q == ST_WAIT);
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_ir.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_ir
// Directed bench for instr_fetch_ir. Expected IR fields are queued when a
// fetch is launched and checked when the memory acknowledge completes it.
// Optional feature macro: FETCH_TIMEOUT_EN (adds the timeout steps).
// -----------------------------------------------------------------------------
module tb_instr_fetch_ir;

  typedef struct {
    logic [31:0] ir;
    logic [6:0]  op;
    logic [14:0] r;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_we = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [14:0] r;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] imm;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fetch_err;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb_q[$];

  instr_fetch_ir #(.XLEN(32), .PC_RESET(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_we(pc_we), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .pc(pc), .ir(ir), .opcode(opcode), .r(r), .funct3(funct3),
    .funct7_b5(funct7_b5), .imm(imm), .ir_valid(ir_valid), .fetch_busy(fetch_busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] w, input logic [14:0] rr, input logic [2:0] f3,
                              input logic f7, input logic [31:0] im, input logic [31:0] p);
    exp_t e;
    e.ir = w; e.op = w[6:0]; e.r = rr; e.f3 = f3; e.f7 = f7; e.imm = im; e.pc = p;
    return e;
  endfunction

  // Launch a fetch at the current PC and queue what it must produce.
  task automatic start_fetch(input logic [31:0] exp_addr, input exp_t e);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    sb_q.push_back(e);
    chk("req_up", {31'h0, imem_req}, 32'd1);
    chk("addr_launch", imem_addr, exp_addr);
    chk("busy_up", {31'h0, fetch_busy}, 32'd1);
    chk("valid_clr", {31'h0, ir_valid}, 32'd0);
  endtask

  task automatic wait_cycles(input int n, input logic [31:0] exp_addr);
    repeat (n) tick();
    chk("addr_hold", imem_addr, exp_addr);
    chk("req_hold", {31'h0, imem_req}, 32'd1);
  endtask

  // Complete the outstanding fetch and compare against the queued entry.
  task automatic ack(input logic [31:0] word);
    exp_t e;
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL sb_empty observed=%0d expected=1", sb_q.size());
    end else begin
      e = sb_q.pop_front();
      chk("ir", ir, e.ir);
      chk("opcode", {25'h0, opcode}, {25'h0, e.op});
      chk("r", {17'h0, r}, {17'h0, e.r});
      chk("funct3", {29'h0, funct3}, {29'h0, e.f3});
      chk("funct7_b5", {31'h0, funct7_b5}, {31'h0, e.f7});
      chk("imm", imm, e.imm);
      chk("pc", pc, e.pc);
      chk("ir_valid", {31'h0, ir_valid}, 32'd1);
      chk("req_down", {31'h0, imem_req}, 32'd0);
      chk("busy_down", {31'h0, fetch_busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held, then released.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_valid", {31'h0, ir_valid}, 32'd0);
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_busy", {31'h0, fetch_busy}, 32'd0);
    chk("rst_err", {31'h0, fetch_err}, 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_pc", pc, 32'h0);
    chk("post_rst_req", {31'h0, imem_req}, 32'd0);

    // addi x1, x0, 10 with a 3-cycle memory wait.
    start_fetch(32'h0, mk(32'h00A0_0093, {5'd1, 5'd0, 5'd10}, 3'd0, 1'b0, 32'd10, 32'h4));
    wait_cycles(3, 32'h0);
    ack(32'h00A0_0093);

    // beq x0,x0,-4
    start_fetch(32'h4, mk(32'hFE00_0EE3, {5'd29, 5'd0, 5'd0}, 3'd0, 1'b1, 32'hFFFF_FFFC, 32'h8));
    ack(32'hFE00_0EE3);
    // lui
    start_fetch(32'h8, mk(32'h1234_5037, {5'd0, 5'd8, 5'd3}, 3'd5, 1'b0, 32'h1234_5000, 32'hC));
    wait_cycles(1, 32'h8);
    ack(32'h1234_5037);
    // sw x2, -8(x3)
    start_fetch(32'hC, mk(32'hFE21_AC23, {5'd24, 5'd3, 5'd2}, 3'd2, 1'b1, 32'hFFFF_FFF8, 32'h10));
    ack(32'hFE21_AC23);
    // jal x0, +8
    start_fetch(32'h10, mk(32'h0080_006F, {5'd0, 5'd0, 5'd8}, 3'd0, 1'b0, 32'h8, 32'h14));
    ack(32'h0080_006F);
    // R-type: no immediate
    start_fetch(32'h14, mk(32'hFFFF_FFB3, {5'd31, 5'd31, 5'd31}, 3'd7, 1'b1, 32'h0, 32'h18));
    ack(32'hFFFF_FFB3);

    // Redirect during WAIT: address held, PC loads aligned target, no +4 on ack.
    start_fetch(32'h18, mk(32'h00A0_0093, {5'd1, 5'd0, 5'd10}, 3'd0, 1'b0, 32'd10, 32'h100));
    pc_we   = 1'b1;
    pc_next = 32'h0000_0103;
    tick();
    pc_we   = 1'b0;
    chk("redir_pc", pc, 32'h100);
    chk("redir_addr", imem_addr, 32'h18);
    wait_cycles(1, 32'h18);
    ack(32'h00A0_0093);

    // fetch_req held during WAIT is ignored; ir_valid persists while idle.
    start_fetch(32'h100, mk(32'h1234_5037, {5'd0, 5'd8, 5'd3}, 3'd5, 1'b0, 32'h1234_5000, 32'h104));
    fetch_req = 1'b1;
    wait_cycles(2, 32'h100);
    fetch_req = 1'b0;
    ack(32'h1234_5037);
    repeat (2) tick();
    chk("valid_sticky", {31'h0, ir_valid}, 32'd1);
    chk("idle_pc", pc, 32'h104);

    // Load in IDLE with misaligned target, then PC+4 wraparound.
    pc_we   = 1'b1;
    pc_next = 32'hFFFF_FFFE;
    tick();
    pc_we   = 1'b0;
    chk("idle_load_pc", pc, 32'hFFFF_FFFC);
    start_fetch(32'hFFFF_FFFC, mk(32'h0080_006F, {5'd0, 5'd0, 5'd8}, 3'd0, 1'b0, 32'h8, 32'h0));
    ack(32'h0080_006F);

    // pc_we on the ack edge takes priority over +4.
    start_fetch(32'h0, mk(32'hFE00_0EE3, {5'd29, 5'd0, 5'd0}, 3'd0, 1'b1, 32'hFFFF_FFFC, 32'h200));
    pc_we   = 1'b1;
    pc_next = 32'h0000_0200;
    ack(32'hFE00_0EE3);
    pc_we   = 1'b0;

    // Reset mid-WAIT, late ack ignored.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("abort_busy_pre", {31'h0, fetch_busy}, 32'd1);
    rst = 1'b0;
    #2;
    chk("abort_req_async", {31'h0, imem_req}, 32'd0);
    chk("abort_pc_async", pc, 32'h0);
    rst = 1'b1;
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h00A0_0093;
    tick();
    imem_ack   = 1'b0;
    chk("abort_ir", ir, 32'h0000_0013);
    chk("abort_valid", {31'h0, ir_valid}, 32'd0);
    chk("abort_req", {31'h0, imem_req}, 32'd0);
    chk("abort_busy", {31'h0, fetch_busy}, 32'd0);
    chk("abort_pc", pc, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // No ack: timeout after 16 WAIT cycles, then next fetch clears the error.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    repeat (15) tick();
    chk("to_busy_15", {31'h0, fetch_busy}, 32'd1);
    tick();
    chk("to_err", {31'h0, fetch_err}, 32'd1);
    chk("to_req", {31'h0, imem_req}, 32'd0);
    chk("to_busy", {31'h0, fetch_busy}, 32'd0);
    chk("to_pc", pc, 32'h0);
    chk("to_ir", ir, 32'h0000_0013);
    start_fetch(32'h0, mk(32'h00A0_0093, {5'd1, 5'd0, 5'd10}, 3'd0, 1'b0, 32'd10, 32'h4));
    chk("to_err_clr", {31'h0, fetch_err}, 32'd0);
    ack(32'h00A0_0093);
`else
    chk("err_tied", {31'h0, fetch_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
